// File: rtl/digit_sequencer_pkg.sv
// Shared FSM encoding and default timing for the digit sequencer.
package digit_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_NUM_DIGITS   = 3;
  localparam int DEF_DISPLAY_TIME = 1000;
  localparam int DEF_PAUSE_TIME   = 500;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/digit_sequencer_if.sv
// Control/status bundle between a host and the digit sequencer.
interface digit_sequencer_if #(
  parameter int IDX_W = 2
);
  logic             trigger;
  logic             abort;
  logic             repeat_en;
  logic [IDX_W:0]   num_digits;
  logic [IDX_W-1:0] digit_idx;
  logic             blank;
  logic             busy;
  logic             digit_start;
  logic             done;

  modport master (
    output trigger, abort, repeat_en, num_digits,
    input  digit_idx, blank, busy, digit_start, done
  );
  modport slave (
    input  trigger, abort, repeat_en, num_digits,
    output digit_idx, blank, busy, digit_start, done
  );
endinterface

// File: rtl/digit_sequencer_phase_timer.sv
// Phase counter: clear/enable, terminal match against one of two limits.
module phase_timer #(
  parameter int CNT_W = 3,
  parameter int LIM_A = 4,
  parameter int LIM_B = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sel,
  output logic match
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  // sel=0 selects the SHOW limit, sel=1 the GAP limit
  assign match = (cnt == (sel ? CNT_W'(LIM_B) : CNT_W'(LIM_A)));
endmodule

// File: rtl/digit_sequencer.sv
// Steps through digits with SHOW/GAP phases; all outputs registered.
module digit_sequencer
  import digit_sequencer_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int DISPLAY_TIME = DEF_DISPLAY_TIME,
  parameter int PAUSE_TIME   = DEF_PAUSE_TIME
) (
  input logic clk,
  input logic rst,
  digit_sequencer_if.slave sif
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(max2(DISPLAY_TIME, PAUSE_TIME) + 1);
  localparam logic [IDX_W:0] MAXC = (IDX_W+1)'(NUM_DIGITS);

  state_t           state, nxt_state;
  logic [IDX_W:0]   count_q, nxt_count, clamped;
  logic [IDX_W-1:0] idx_q, nxt_idx;
  logic             blank_q, busy_q, ds_q, done_q;
  logic             nxt_ds, nxt_done;
  logic             match, accept, show_end, gap_end, last;

  phase_timer #(.CNT_W(CNT_W), .LIM_A(DISPLAY_TIME), .LIM_B(PAUSE_TIME)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state == IDLE) || (nxt_state != state)),
    .en    (state != IDLE),
    .sel   (state == GAP),
    .match (match)
  );

  always_comb begin
    clamped = sif.num_digits;
    if (sif.num_digits == '0)       clamped = (IDX_W+1)'(1);
    else if (sif.num_digits > MAXC) clamped = MAXC;
  end

  assign accept   = (state == IDLE) && sif.trigger;
  assign show_end = (state == SHOW) && match;
  assign gap_end  = (state == GAP) && match;
  assign last     = ({1'b0, idx_q} == count_q - (IDX_W+1)'(1));

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count_q <= (IDX_W+1)'(1);
      idx_q   <= '0;
      blank_q <= 1'b1;
      busy_q  <= 1'b0;
      ds_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      count_q <= nxt_count;
      idx_q   <= nxt_idx;
      blank_q <= (nxt_state != SHOW);
      busy_q  <= (nxt_state != IDLE);
      ds_q    <= nxt_ds;
      done_q  <= nxt_done;
    end
  end

  always_comb begin
    nxt_state = state;
    if (sif.abort) nxt_state = IDLE;
    else begin
      case (state)
        IDLE:    if (accept)   nxt_state = SHOW;
        SHOW:    if (show_end) nxt_state = GAP;
        GAP:     if (gap_end)  nxt_state = (last && !sif.repeat_en) ? IDLE : SHOW;
        default:               nxt_state = IDLE;
      endcase
    end
  end

  always_comb begin
    nxt_count = count_q;
    nxt_idx   = idx_q;
    nxt_ds    = 1'b0;
    nxt_done  = 1'b0;
    if (sif.abort) nxt_idx = '0;
    else if (accept) begin
      nxt_count = clamped;
      nxt_idx   = '0;
      nxt_ds    = 1'b1;
    end else if (gap_end) begin
      if (last) begin
        nxt_done = 1'b1;
        nxt_idx  = '0;
        nxt_ds   = sif.repeat_en;
      end else begin
        nxt_idx = idx_q + IDX_W'(1);
        nxt_ds  = 1'b1;
      end
    end else if (state == IDLE) nxt_idx = '0;
  end

  assign sif.digit_idx   = idx_q;
  assign sif.blank       = blank_q;
  assign sif.busy        = busy_q;
  assign sif.digit_start = ds_q;
  assign sif.done        = done_q;
endmodule

// File: tb/tb_digit_sequencer.sv
// Directed bench: short vectors table plus hand-written pass sequences.
module tb_digit_sequencer;
  localparam int ND = 5;
  localparam int IW = $clog2(ND);

  logic clk, rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  digit_sequencer_if #(.IDX_W(IW)) sif ();
  digit_sequencer_if #(.IDX_W(2))  dif ();

  digit_sequencer #(.NUM_DIGITS(ND), .DISPLAY_TIME(4), .PAUSE_TIME(2)) dut (
    .clk(clk), .rst(rst), .sif(sif)
  );
  digit_sequencer dut_def (.clk(clk), .rst(rst), .sif(dif));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        tr;
    logic        ab;
    logic [IW:0] nd;
    logic [6:0]  exp;
  } vec_t;

  localparam logic [6:0] IDLE_O = 7'b000_1000;

  function automatic logic [6:0] outs();
    return {sif.digit_idx, sif.blank, sif.busy, sif.digit_start, sif.done};
  endfunction

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (idx,blank,busy,start,done)", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic start(input logic [IW:0] nd, input logic rep);
    sif.num_digits = nd;
    sif.repeat_en  = rep;
    sif.trigger    = 1;
    @(negedge clk);
    sif.trigger    = 0;
  endtask

  // Each digit: 5 SHOW clocks then 3 GAP clocks; t=0 is the first SHOW clock.
  task automatic run_pass(input string nm, input int ndig, input bit first_done,
                          input int drop_rep_at, input int abort_at, input int perturb_at);
    for (int t = 0; t < ndig * 8; t++) begin
      int ph;
      ph = t % 8;
      chk($sformatf("%s t=%0d", nm, t), outs(),
          {3'(t / 8), ph >= 5, 1'b1, ph == 0, (t == 0) && first_done});
      if (t == abort_at) begin
        sif.abort = 1;
        @(negedge clk);
        sif.abort = 0;
        return;
      end
      if (t == drop_rep_at) sif.repeat_en = 0;
      if (t == perturb_at) begin
        sif.trigger    = 1;
        sif.num_digits = 1;
      end else if (t == perturb_at + 1) begin
        sif.trigger    = 0;
      end
      @(negedge clk);
    end
  endtask

  vec_t vt[7];
  int   n_show, n_gap;

  initial begin
    vt[0] = '{tr:1, ab:1, nd:3, exp:IDLE_O};        // trigger+abort in IDLE
    vt[1] = '{tr:0, ab:0, nd:3, exp:IDLE_O};
    vt[2] = '{tr:1, ab:0, nd:3, exp:7'b000_0110};   // accepted: SHOW, start
    vt[3] = '{tr:1, ab:0, nd:3, exp:7'b000_0100};   // trigger while busy ignored
    vt[4] = '{tr:0, ab:1, nd:3, exp:IDLE_O};        // abort from SHOW
    vt[5] = '{tr:1, ab:0, nd:0, exp:7'b000_0110};
    vt[6] = '{tr:1, ab:1, nd:0, exp:IDLE_O};        // abort beats busy trigger

    rst = 1;
    sif.trigger = 0; sif.abort = 0; sif.repeat_en = 0; sif.num_digits = 3;
    dif.trigger = 0; dif.abort = 0; dif.repeat_en = 0; dif.num_digits = 1;
    @(negedge clk);
    chk("reset", outs(), IDLE_O);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("idle after reset", outs(), IDLE_O);

    for (int i = 0; i < 7; i++) begin
      sif.trigger    = vt[i].tr;
      sif.abort      = vt[i].ab;
      sif.num_digits = vt[i].nd;
      @(negedge clk);
      chk($sformatf("vec %0d", i), outs(), vt[i].exp);
    end
    sif.trigger = 0; sif.abort = 0;
    @(negedge clk);

    // three-digit single pass, done at clock 24
    start(3, 0);
    run_pass("pass3", 3, 0, -1, -1, -1);
    chk("pass3 done", outs(), 7'b000_1001);
    @(negedge clk);
    chk("pass3 idle", outs(), IDLE_O);

    // clamping
    start(0, 0);
    run_pass("nd0", 1, 0, -1, -1, -1);
    chk("nd0 done", outs(), 7'b000_1001);
    @(negedge clk);
    start(ND + 5, 0);
    run_pass("ndbig", ND, 0, -1, -1, -1);
    chk("ndbig done", outs(), 7'b000_1001);
    @(negedge clk);

    // repeat: done every 16 clocks, then stop after dropping repeat_en
    start(2, 1);
    run_pass("rep p1", 2, 0, -1, -1, -1);
    run_pass("rep p2", 2, 1, -1, -1, -1);
    run_pass("rep p3", 2, 1, 3, -1, -1);
    chk("rep end", outs(), 7'b000_1001);
    @(negedge clk);
    chk("rep idle", outs(), IDLE_O);

    // abort at SHOW clock 2 of digit 1
    start(3, 0);
    run_pass("abort", 3, 0, -1, 10, -1);
    chk("abort idle", outs(), IDLE_O);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort no done %0d", i), outs(), IDLE_O);
    end

    // mid-pass trigger and num_digits change have no effect
    start(3, 0);
    run_pass("perturb", 3, 0, -1, -1, 10);
    chk("perturb done", outs(), 7'b000_1001);
    sif.num_digits = 3;
    @(negedge clk);

    // asynchronous reset in GAP, then a clean restart
    start(3, 0);
    repeat (6) @(negedge clk);
    chk("pre-rst gap", outs(), 7'b000_1100);
    #2 rst = 1;
    #1 chk("async rst", outs(), IDLE_O);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    start(2, 0);
    chk("post-rst start", outs(), 7'b000_0110);
    sif.abort = 1;
    @(negedge clk);
    sif.abort = 0;

    // default timing instance: SHOW 1001, GAP 501 clocks
    dif.num_digits = 1;
    dif.trigger = 1;
    @(negedge clk);
    dif.trigger = 0;
    n_show = 0;
    while (dif.busy && !dif.blank && n_show < 3000) begin
      n_show++;
      @(negedge clk);
    end
    n_gap = 0;
    while (dif.busy && dif.blank && n_gap < 3000) begin
      n_gap++;
      @(negedge clk);
    end
    chk_int("default show len", n_show, 1001);
    chk_int("default gap len", n_gap, 501);
    chk_int("default done", int'(dif.done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/digit_sequencer.md
DIGIT_SEQUENCER -- requirements
Module: digit_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 3; maximum number of digits per pass, legal range 2..16.
REQ-002 The block SHALL have parameter DISPLAY_TIME, default 1000; the SHOW phase lasts DISPLAY_TIME+1 clocks.
REQ-003 The block SHALL have parameter PAUSE_TIME, default 500; the GAP phase lasts PAUSE_TIME+1 clocks.
REQ-004 The block SHALL have derived constants IDX_W = clog2(NUM_DIGITS) and CNT_W = clog2(max(DISPLAY_TIME,PAUSE_TIME)+1).
REQ-005 clk  in  1  the single clock; all state changes occur on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 trigger  in  1  starts a pass when the block is idle.
REQ-008 abort  in  1  terminates any pass at once.
REQ-009 repeat_en  in  1  when high, the block loops passes continuously.
REQ-010 num_digits  in  IDX_W+1  digit count for the pass, sampled on the accepted trigger.
REQ-011 digit_idx  out  IDX_W  index of the digit currently shown.
REQ-012 blank  out  1  high when no digit is shown (IDLE or GAP).
REQ-013 busy  out  1  high when the FSM is not IDLE.
REQ-014 digit_start  out  1  one-clock pulse on the first SHOW clock of each digit.
REQ-015 done  out  1  one-clock pulse at the end of each completed pass.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHOW and GAP.
REQ-017 IDLE with trigger=1 and abort=0 SHALL, on the next clock, enter SHOW with digit_idx=0, the counter at 0 and a digit_start pulse.
REQ-018 A trigger while busy SHALL be ignored.
REQ-019 The latched count SHALL be num_digits clamped to 1..NUM_DIGITS (0 becomes 1; values above NUM_DIGITS become NUM_DIGITS).
REQ-020 The counter SHALL increment every clock in SHOW and GAP.
REQ-021 When the SHOW counter equals DISPLAY_TIME, the block SHALL enter GAP with blank=1 and the counter at 0.
REQ-022 When the GAP counter equals PAUSE_TIME and digit_idx is below count-1, the block SHALL enter SHOW with digit_idx+1 and pulse digit_start.
REQ-023 When the GAP counter equals PAUSE_TIME and digit_idx equals count-1, done SHALL pulse on that same transition.
REQ-024 At that transition, if repeat_en=1 (sampled then), the block SHALL enter SHOW with digit_idx=0 and pulse digit_start; otherwise it SHALL enter IDLE.
REQ-025 num_digits changes mid-pass SHALL have no effect; a repeated pass SHALL reuse the latched count.
REQ-026 abort=1 in any state SHALL force IDLE on the next clock with blank=1, digit_idx=0, busy=0 and no done pulse.
REQ-027 abort SHALL win over trigger and over a simultaneous phase completion.
REQ-028 digit_idx SHALL hold its value during GAP and SHALL be 0 in IDLE.
REQ-029 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-030 done and digit_start SHALL never be high for two consecutive clocks.

Reset
REQ-031 Asserting rst SHALL immediately set state=IDLE, counter=0, digit_idx=0, blank=1, busy=0, digit_start=0 and done=0, including mid-pass.
REQ-032 The first trigger after rst deasserts SHALL be handled per REQ-017.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE/SHOW/GAP) and the default timing constants.
REQ-034 One sub-module, phase_timer (CNT_W-bit counter with clear, enable and terminal-match compare against a selectable limit), SHALL provide the counter.
REQ-035 The FSM and output registers SHALL reside in digit_sequencer.

Verification (DISPLAY_TIME=4, PAUSE_TIME=2 unless stated)
REQ-036 Bench SHALL cover: trigger, num_digits=3, repeat_en=0 -> digit_idx 0,1,2, each SHOW 5 clocks and GAP 3 clocks; done pulses once at clock 24 after entering SHOW; busy=0 after.
REQ-037 Bench SHALL cover: num_digits=0 and num_digits=NUM_DIGITS+5 -> exactly 1 and NUM_DIGITS digits shown, respectively.
REQ-038 Bench SHALL cover: repeat_en=1, num_digits=2 -> done every 16 clocks, with digit_idx returning to 0 and busy staying high; repeat_en dropped -> IDLE after the current pass.
REQ-039 Bench SHALL cover: abort at SHOW clock 2 of digit 1 -> IDLE next clock, blank=1, no done; a trigger in the same clock as abort in IDLE -> stays IDLE.
REQ-040 Bench SHALL cover: trigger re-pulsed mid-pass and num_digits changed mid-pass -> no change in sequence or timing.
REQ-041 Bench SHALL cover: rst asserted mid-GAP -> all outputs at reset values asynchronously; defaults 1000/500 -> SHOW 1001 and GAP 501 clocks.
